// File: rtl/univ_shift_reg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg
//   WIDTH-bit universal shift register. It supports parallel load, logical
//   shifts, rotates and arithmetic shift right, all selected by a mode code.
//   A small FSM repeats a shift or rotate 'amount' times from a single start
//   pulse. While a run is in progress the FSM reports busy, and it emits a
//   one-cycle done pulse when the run ends.
//
// Ports
//   clk     : rising-edge clock
//   reset   : asynchronous active-low reset (clears every state bit)
//   en      : single-step enable; runs 'mode' once when not busy
//   clr     : synchronous clear, highest synchronous priority
//   mode    : 000 hold, 001 load, 010 SHL, 011 SHR, 100 ROL, 101 ROR,
//             110 ASR, 111 hold
//   din     : parallel load data
//   sin_l   : serial bit entering the MSB on SHR
//   sin_r   : serial bit entering the LSB on SHL
//   start   : begin an auto-repeat run of 'mode' for 'amount' steps
//   amount  : repeat count, latched at start
//   q       : register contents
//   sout_l  : q[WIDTH-1]
//   sout_r  : q[0]
//   busy    : auto-repeat run in progress
//   done    : one-cycle pulse at the end of a run or start request
// ---------------------------------------------------------------------------
module univ_shift_reg #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] din,
   input  logic             sin_l,
   input  logic             sin_r,
   input  logic             start,
   input  logic [CNT_W-1:0] amount,
   output logic [WIDTH-1:0] q,
   output logic             sout_l,
   output logic             sout_r,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_LOAD = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_SHR  = 3'b011;
   localparam logic [2:0] MODE_ROL  = 3'b100;
   localparam logic [2:0] MODE_ROR  = 3'b101;
   localparam logic [2:0] MODE_ASR  = 3'b110;

   typedef enum logic {S_IDLE, S_RUN} state_e;

   state_e           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       mode_lat, mode_lat_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic             done_nxt;

   // One step of the selected operation applied to 'cur'.
   function automatic logic [WIDTH-1:0] apply_op(
      input logic [2:0]       op,
      input logic [WIDTH-1:0] cur,
      input logic [WIDTH-1:0] load_val,
      input logic             left_in,
      input logic             right_in
   );
      logic [WIDTH-1:0] res;
      res = cur;
      case (op)
         MODE_LOAD: res = load_val;
         MODE_SHL:  res = {cur[WIDTH-2:0], right_in};
         MODE_SHR:  res = {left_in, cur[WIDTH-1:1]};
         MODE_ROL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
         MODE_ROR:  res = {cur[0], cur[WIDTH-1:1]};
         MODE_ASR:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
         default:   res = cur;  // 000 and 111 both hold
      endcase
      return res;
   endfunction

   // Only the shift/rotate codes are repeatable; hold and load run once.
   function automatic logic is_repeatable(input logic [2:0] op);
      return (op >= MODE_SHL) && (op <= MODE_ASR);
   endfunction

   // State register.
   // NOTE: sequential state uses non-blocking assignments so that every
   // flop samples values from before the edge, whatever order blocks run in.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         mode_lat <= MODE_HOLD;
         q        <= '0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         mode_lat <= mode_lat_nxt;
         q        <= q_nxt;
         done     <= done_nxt;
      end
   end

   // Next-state logic, in per-edge priority order: clr, run, start, en.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      state_nxt    = state;
      cnt_nxt      = cnt;
      mode_lat_nxt = mode_lat;
      q_nxt        = q;
      done_nxt     = 1'b0;

      if (clr) begin
         state_nxt = S_IDLE;
         cnt_nxt   = '0;
         q_nxt     = '0;
      end else if (state == S_RUN) begin
         // Inputs en/start/mode are ignored; the latched mode drives the run.
         q_nxt   = apply_op(mode_lat, q, din, sin_l, sin_r);
         cnt_nxt = cnt - CNT_W'(1);
         if (cnt == CNT_W'(1)) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
         end
      end else if (start) begin
         mode_lat_nxt = mode;
         if (is_repeatable(mode)) begin
            cnt_nxt = amount;
            // A zero-length run completes immediately with q untouched.
            if (amount != '0) state_nxt = S_RUN;
            else              done_nxt  = 1'b1;
         end else begin
            cnt_nxt  = '0;
            q_nxt    = apply_op(mode, q, din, sin_l, sin_r);
            done_nxt = 1'b1;
         end
      end else if (en) begin
         q_nxt = apply_op(mode, q, din, sin_l, sin_r);
      end
   end

   // Output decode.
   always_comb begin
      busy   = (state == S_RUN);
      sout_l = q[WIDTH-1];
      sout_r = q[0];
   end

endmodule

// File: tb/tb_univ_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_univ_shift_reg
//   Self-checking bench for univ_shift_reg (WIDTH=8, CNT_W=4). Each
//   stimulus step drives one cycle of inputs and queues the hand-computed
//   state expected after the next rising edge. A monitor pops one entry
//   shortly after each rising edge and compares it with the DUT outputs.
//   Asynchronous-reset behaviour is checked directly between edges.
// ---------------------------------------------------------------------------
module tb_univ_shift_reg;

   logic       clk;
   logic       reset;
   logic       en;
   logic       clr;
   logic [2:0] mode;
   logic [7:0] din;
   logic       sin_l;
   logic       sin_r;
   logic       start;
   logic [3:0] amount;
   logic [7:0] q;
   logic       sout_l;
   logic       sout_r;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] q;
      logic       busy;
      logic       done;
      string      name;
   } exp_t;

   exp_t sb[$];

   univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .clr    (clr),
      .mode   (mode),
      .din    (din),
      .sin_l  (sin_l),
      .sin_r  (sin_r),
      .start  (start),
      .amount (amount),
      .q      (q),
      .sout_l (sout_l),
      .sout_r (sout_r),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs and queue the state expected after the edge.
   task automatic step(input logic en_v, input logic clr_v, input logic start_v,
                       input logic [2:0] mode_v, input logic [7:0] din_v,
                       input logic sl_v, input logic sr_v, input logic [3:0] amt_v,
                       input logic [7:0] eq, input logic eb, input logic ed,
                       input string name);
      exp_t e;
      @(negedge clk);
      en     = en_v;
      clr    = clr_v;
      start  = start_v;
      mode   = mode_v;
      din    = din_v;
      sin_l  = sl_v;
      sin_r  = sr_v;
      amount = amt_v;
      e.q    = eq;
      e.busy = eb;
      e.done = ed;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic idle(input logic [7:0] eq, input logic eb, input logic ed, input string name);
      step(1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 4'd0, eq, eb, ed, name);
   endtask

   // Monitor: compare the queued expectation just after every rising edge.
   always begin
      exp_t e;
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({e.name, ".q"},      32'(q),      32'(e.q));
         check({e.name, ".busy"},   32'(busy),   32'(e.busy));
         check({e.name, ".done"},   32'(done),   32'(e.done));
         check({e.name, ".sout_l"}, 32'(sout_l), 32'(e.q[7]));
         check({e.name, ".sout_r"}, 32'(sout_r), 32'(e.q[0]));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset  = 1'b0;
      en     = 1'b0;
      clr    = 1'b0;
      start  = 1'b0;
      mode   = 3'b000;
      din    = 8'h00;
      sin_l  = 1'b0;
      sin_r  = 1'b0;
      amount = 4'd0;

      #1;
      check("por.q",    32'(q),    32'h0);
      check("por.busy", 32'(busy), 32'h0);
      check("por.done", 32'(done), 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // Asynchronous reset in the middle of a run.
      step(1'b1, 1'b0, 1'b0, 3'b001, 8'hA5, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0, "rst_load");
      step(1'b0, 1'b0, 1'b1, 3'b010, 8'h00, 1'b0, 1'b0, 4'd5, 8'hA5, 1'b1, 1'b0, "rst_start");
      @(negedge clk);
      #1 reset = 1'b0;
      #1;
      check("rst_async.q",    32'(q),    32'h0);
      check("rst_async.busy", 32'(busy), 32'h0);
      check("rst_async.done", 32'(done), 32'h0);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      idle(8'h00, 1'b0, 1'b0, "rst_after1");
      idle(8'h00, 1'b0, 1'b0, "rst_after2");
      idle(8'h00, 1'b0, 1'b0, "rst_after3");

      // Single-step load then rotate left.
      step(1'b1, 1'b0, 1'b0, 3'b001, 8'h96, 1'b0, 1'b0, 4'd0, 8'h96, 1'b0, 1'b0, "en_load");
      step(1'b1, 1'b0, 1'b0, 3'b100, 8'h00, 1'b0, 1'b0, 4'd0, 8'h2D, 1'b0, 1'b0, "en_rol");
      step(1'b1, 1'b0, 1'b0, 3'b111, 8'hFF, 1'b1, 1'b1, 4'd0, 8'h2D, 1'b0, 1'b0, "en_hold7");

      // ROR run of 3 with en toggling (ignored while busy).
      step(1'b1, 1'b0, 1'b0, 3'b001, 8'h81, 1'b0, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0, "ror_load");
      step(1'b0, 1'b0, 1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 4'd3, 8'h81, 1'b1, 1'b0, "ror_start");
      step(1'b1, 1'b0, 1'b0, 3'b001, 8'hFF, 1'b0, 1'b0, 4'd0, 8'hC0, 1'b1, 1'b0, "ror_s1");
      step(1'b0, 1'b0, 1'b0, 3'b001, 8'hFF, 1'b0, 1'b0, 4'd0, 8'h60, 1'b1, 1'b0, "ror_s2");
      step(1'b1, 1'b0, 1'b1, 3'b001, 8'hFF, 1'b0, 1'b0, 4'd9, 8'h30, 1'b0, 1'b1, "ror_s3");
      idle(8'h30, 1'b0, 1'b0, "ror_done_off");

      // ASR run of 4, then back-to-back SHR run started in the done cycle.
      step(1'b1, 1'b0, 1'b0, 3'b001, 8'h80, 1'b0, 1'b0, 4'd0, 8'h80, 1'b0, 1'b0, "asr_load");
      step(1'b0, 1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 4'd4, 8'h80, 1'b1, 1'b0, "asr_start");
      step(1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 1'b1, 1'b0, 4'd0, 8'hC0, 1'b1, 1'b0, "asr_s1");
      step(1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 1'b1, 1'b0, 4'd0, 8'hE0, 1'b1, 1'b0, "asr_s2");
      step(1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 1'b1, 1'b0, 4'd0, 8'hF0, 1'b1, 1'b0, "asr_s3");
      step(1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 1'b1, 1'b0, 4'd0, 8'hF8, 1'b0, 1'b1, "asr_s4");
      step(1'b0, 1'b0, 1'b1, 3'b011, 8'h00, 1'b0, 1'b0, 4'd2, 8'hF8, 1'b1, 1'b0, "shr_start");
      step(1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 4'd0, 8'h7C, 1'b1, 1'b0, "shr_s1");
      step(1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 4'd0, 8'h3E, 1'b0, 1'b1, "shr_s2");
      idle(8'h3E, 1'b0, 1'b0, "shr_done_off");

      // amount=0 with a shift mode, then start with load mode.
      step(1'b0, 1'b0, 1'b1, 3'b010, 8'h00, 1'b0, 1'b1, 4'd0, 8'h3E, 1'b0, 1'b1, "zero_start");
      idle(8'h3E, 1'b0, 1'b0, "zero_after");
      step(1'b0, 1'b0, 1'b1, 3'b001, 8'h5A, 1'b0, 1'b0, 4'd7, 8'h5A, 1'b0, 1'b1, "ld_start");
      idle(8'h5A, 1'b0, 1'b0, "ld_after");

      // clr on the second step of an amount=5 SHL run.
      step(1'b0, 1'b0, 1'b1, 3'b010, 8'h00, 1'b0, 1'b1, 4'd5, 8'h5A, 1'b1, 1'b0, "clr_start");
      step(1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1, 4'd0, 8'hB5, 1'b1, 1'b0, "clr_s1");
      step(1'b0, 1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1, 4'd0, 8'h00, 1'b0, 1'b0, "clr_hit");
      idle(8'h00, 1'b0, 1'b0, "clr_after1");
      idle(8'h00, 1'b0, 1'b0, "clr_after2");
      idle(8'h00, 1'b0, 1'b0, "clr_after3");
      step(1'b1, 1'b0, 1'b0, 3'b001, 8'h5A, 1'b0, 1'b0, 4'd0, 8'h5A, 1'b0, 1'b0, "clr_en_pre");
      step(1'b1, 1'b1, 1'b0, 3'b001, 8'hFF, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, "clr_en_load");

      // Eight SHL steps of ones fully replace an all-zero register.
      step(1'b0, 1'b0, 1'b1, 3'b010, 8'h00, 1'b0, 1'b1, 4'd8, 8'h00, 1'b1, 1'b0, "fill_start");
      step(1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1, 4'd0, 8'h01, 1'b1, 1'b0, "fill_s1");
      step(1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1, 4'd0, 8'h03, 1'b1, 1'b0, "fill_s2");
      step(1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1, 4'd0, 8'h07, 1'b1, 1'b0, "fill_s3");
      step(1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1, 4'd0, 8'h0F, 1'b1, 1'b0, "fill_s4");
      step(1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1, 4'd0, 8'h1F, 1'b1, 1'b0, "fill_s5");
      step(1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1, 4'd0, 8'h3F, 1'b1, 1'b0, "fill_s6");
      step(1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1, 4'd0, 8'h7F, 1'b1, 1'b0, "fill_s7");
      step(1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1, 4'd0, 8'hFF, 1'b0, 1'b1, "fill_s8");
      idle(8'hFF, 1'b0, 1'b0, "fill_after");

      // Let the monitor drain the last entry; a leftover entry is an error.
      repeat (3) @(posedge clk);
      #3;
      check("scoreboard_drained", 32'(sb.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
